apb_mem_completer: RTL and testbench
====================================

Name: apb_mem_completer

Overview:
- APB3 completer (slave) memory module on the peripheral bus of the cpu/APB subsystem.
- It responds to the transfers the CPU's APB master issues for opcode 100 (write) and opcode 101 (read).
- It provides a word-addressed register-file memory with programmable wait states and PSLVERR for out-of-range addresses.
- It sits behind the master's PSEL decode, and its PRDATA returns to the master's read path.

Parameters:
- ADDR_WIDTH, 8: width of paddr; this is the address field of the CPU instruction.
- DATA_WIDTH, 32: width of pwdata/prdata.
- DEPTH, 128: number of implemented words; valid addresses are 0..DEPTH-1.
- WAIT_STATES, 0: extra ACCESS cycles inserted before pready (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- psel  input  1  APB select for this completer.
- penable  input  1  APB enable; high marks the ACCESS phase.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_WIDTH  word address.
- pwdata  input  DATA_WIDTH  write data.
- prdata  output  DATA_WIDTH  read data; valid only while pready=1 and pwrite=0.
- pready  output  1  transfer completes this cycle.
- pslverr  output  1  error response; valid only while pready=1.
- err_count  output  8  number of errored or aborted transfers, saturating.

Behaviour:
- Reset (asynchronous, any cycle):
  - state=IDLE; pready=0, pslverr=0, prdata=0, err_count=0.
  - All DEPTH memory words cleared to 0.
  - An in-flight transfer is discarded and no write is committed.
- State machine:
  - IDLE: on psel=1 and penable=0, go to SETUP.
  - SETUP (1 cycle):
    - Latch paddr, pwdata, pwrite.
    - Load wait counter = WAIT_STATES.
    - Compute err = (paddr >= DEPTH).
    - Go to ACCESS.
  - ACCESS:
    - Stay while cnt != 0, decrementing cnt each cycle.
    - When cnt == 0, assert pready for exactly that cycle, then go to IDLE.
    - If psel=1 and penable=0 in that same completion cycle, go directly to SETUP (back-to-back).
- Timing: all outputs are registered. With WAIT_STATES=N, the master sees N+1 ACCESS cycles, and pready is high only in the last one.
- Read completion:
  - prdata = mem[latched addr]; pslverr=0.
  - If err: prdata=0 and pslverr=1.
- Write completion:
  - mem[latched addr] <= latched pwdata on the completion edge; pslverr=0.
  - If err: no memory change and pslverr=1.
- Hold-off: prdata returns to 0 and pslverr to 0 in every cycle where pready=0.
- Protocol violation: psel or penable low while in ACCESS before completion.
  - Abort to IDLE; no write is committed; pready stays 0.
  - err_count increments.
- Latching: pwdata/paddr changes during ACCESS are ignored; the SETUP-latched values are used.
- err_count: increments once per errored completion or abort, and saturates at 255 (no wrap).
- Read-after-write: a read to an address written in the immediately preceding transfer returns the new data.
- penable=1 while in IDLE (no SETUP seen): ignored and no response; pready stays 0.

Test Plan:
- WAIT_STATES=0: write 0x00000003 to addr 0x01 (SETUP, ACCESS), then read addr 0x01 -> pready high in the first ACCESS cycle of each transfer; prdata=0x00000003; pslverr=0.
- WAIT_STATES=3: write 0x0000000F to addr 0x02, then read it back.
  - pready low for 3 ACCESS cycles, then high in the 4th.
  - prdata=0x0000000F only in that cycle, 0 otherwise.
- Back-to-back: write 0x1F to addr 0x03, with the next SETUP (read 0x03) in the completion cycle -> no idle gap; read returns 0x0000001F.
- Error: read addr 0x80 and write 0xDEAD to addr 0xFF with DEPTH=128.
  - Each gets pready=1 with pslverr=1, and prdata=0 on the read.
  - err_count=2; a subsequent read of addr 0x7F returns 0.
- Abort: WAIT_STATES=2, write 0x55 to addr 0x04, drop psel in the 2nd ACCESS cycle.
  - No pready; err_count increments.
  - A later read of 0x04 returns 0.
- Reset mid-ACCESS after a prior write of 0x3 to addr 0x01 -> outputs 0 immediately (asynchronous); err_count=0; a subsequent read of 0x01 returns 0.

Source files
------------

// File: rtl/apb_mem_completer.sv
// APB3 completer backed by a word-addressed register-file memory.
// Supports programmable wait states, PSLVERR for out-of-range addresses, and a saturating error counter.
module apb_mem_completer #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH       = 128,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr,
   output logic [7:0]            err_count
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = 4;

   // The master's SETUP cycle is sampled in StIdle (or in a completion cycle).
   // Transfer parameters are latched on that edge, so pready can rise in the first ACCESS cycle.
   typedef enum logic [0:0] {StIdle, StAccess} state_e;

   state_e                state_q;
   logic [IdxW-1:0]       addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  wr_q;
   logic                  err_q;
   logic [CntW-1:0]       cnt_q;
   logic                  pready_q;
   logic                  pslverr_q;
   logic [DATA_WIDTH-1:0] prdata_q;
   logic [7:0]            err_count_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  done, commit, setup_ok, abort, new_err;
   logic                  fin_now, fin_err, fin_wr, err_inc;
   logic [DATA_WIDTH-1:0] live_rd, fin_rd;

   always_comb begin
      done     = (state_q == StAccess) && pready_q;
      commit   = done && wr_q && !err_q;
      setup_ok = psel && !penable && ((state_q == StIdle) || done);
      abort    = (state_q == StAccess) && !pready_q && !(psel && penable);
      new_err  = 32'(paddr) >= DEPTH;
      live_rd  = mem_q[paddr[IdxW-1:0]];
      // Forward a write that commits on the same edge a new read is sampled.
      if (commit && (addr_q == paddr[IdxW-1:0])) begin
         live_rd = wdata_q;
      end
      fin_now = (setup_ok && (WAIT_STATES == 0)) ||
                ((state_q == StAccess) && !pready_q && !abort && (cnt_q == CntW'(1)));
      fin_err = setup_ok ? new_err : err_q;
      fin_wr  = setup_ok ? pwrite  : wr_q;
      fin_rd  = setup_ok ? live_rd : mem_q[addr_q];
      err_inc = abort || (fin_now && fin_err);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         pready_q    <= 1'b0;
         pslverr_q   <= 1'b0;
         prdata_q    <= '0;
         err_count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         if (commit) begin
            mem_q[addr_q] <= wdata_q;
         end
         if (err_inc && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
         end
         if (setup_ok) begin
            state_q <= StAccess;
            addr_q  <= paddr[IdxW-1:0];
            wdata_q <= pwdata;
            wr_q    <= pwrite;
            err_q   <= new_err;
            cnt_q   <= CntW'(WAIT_STATES);
         end else if (state_q == StAccess) begin
            if (pready_q || abort) begin
               state_q <= StIdle;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
         end
         if (fin_now) begin
            pready_q  <= 1'b1;
            pslverr_q <= fin_err;
            if (!fin_wr && !fin_err) begin
               prdata_q <= fin_rd;
            end
         end
      end
   end

   assign prdata    = prdata_q;
   assign pready    = pready_q;
   assign pslverr   = pslverr_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_apb_mem_completer.sv
// Bench for apb_mem_completer: three instances (0, 2, 3 wait states) checked against an array model.
module tb_apb_mem_completer;

   logic        clk = 1'b0;
   logic        reset;
   logic        psel [3];
   logic        penable [3];
   logic        pwrite [3];
   logic [7:0]  paddr [3];
   logic [31:0] pwdata [3];
   logic [31:0] prdata [3];
   logic        pready [3];
   logic        pslverr [3];
   logic [7:0]  err_count [3];

   logic [31:0] mmem [3][128];
   int          errc [3];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      apb_mem_completer #(
         .ADDR_WIDTH (8),
         .DATA_WIDTH (32),
         .DEPTH      (128),
         .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
      ) u_dut (
         .clk      (clk),
         .reset    (reset),
         .psel     (psel[g]),
         .penable  (penable[g]),
         .pwrite   (pwrite[g]),
         .paddr    (paddr[g]),
         .pwdata   (pwdata[g]),
         .prdata   (prdata[g]),
         .pready   (pready[g]),
         .pslverr  (pslverr[g]),
         .err_count(err_count[g])
      );
   end

   function automatic int ws(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
   endfunction

   function automatic int sat_inc(input int v);
      return (v < 255) ? v + 1 : 255;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 3; k++) begin
         errc[k] = 0;
         for (int i = 0; i < 128; i++) mmem[k][i] = '0;
      end
   endtask

   task automatic bus_idle(input int k);
      @(posedge clk); #1;
      psel[k] = 1'b0; penable[k] = 1'b0;
   endtask

   // Full transfer; returns with the bus still in the completion cycle.
   task automatic xfer(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d,
                       input string tag);
      int          waits;
      bit          got;
      bit          exp_err;
      logic [31:0] exp_rd;
      exp_err = (a >= 8'd128);
      exp_rd  = exp_err ? 32'h0 : mmem[k][a[6:0]];
      @(posedge clk); #1;
      psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
      @(negedge clk);
      n_cmp++;
      if (pready[k] !== 1'b0) begin
         n_bad++; $display("FAIL %s setup_pready got %b want 0", tag, pready[k]);
      end
      @(posedge clk); #1;
      penable[k] = 1'b1; paddr[k] = 8'($urandom); pwdata[k] = $urandom;
      waits = 0; got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (pready[k] === 1'b1) begin
            got = 1'b1;
         end else begin
            n_cmp++;
            if (prdata[k] !== 32'h0 || pslverr[k] !== 1'b0) begin
               n_bad++;
               $display("FAIL %s holdoff got prdata=%h pslverr=%b want 0/0", tag, prdata[k],
                        pslverr[k]);
            end
            waits++;
            @(posedge clk); #1;
            paddr[k] = 8'($urandom); pwdata[k] = $urandom;
         end
      end
      n_cmp++;
      if (!got) begin
         n_bad++; $display("FAIL %s timeout got no pready want pready within 20", tag);
      end else begin
         n_cmp++;
         if (waits != ws(k)) begin
            n_bad++; $display("FAIL %s wait_cycles got %0d want %0d", tag, waits, ws(k));
         end
         n_cmp++;
         if (pslverr[k] !== exp_err) begin
            n_bad++; $display("FAIL %s pslverr got %b want %b", tag, pslverr[k], exp_err);
         end
         if (!wr) begin
            n_cmp++;
            if (prdata[k] !== exp_rd) begin
               n_bad++; $display("FAIL %s prdata got %h want %h", tag, prdata[k], exp_rd);
            end
         end
      end
      if (wr && !exp_err) mmem[k][a[6:0]] = d;
      if (exp_err) errc[k] = sat_inc(errc[k]);
   endtask

   task automatic check_errc(input int k, input string tag);
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (err_count[k] !== 8'(errc[k])) begin
         n_bad++; $display("FAIL %s err_count got %0d want %0d", tag, err_count[k], errc[k]);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         psel[k] = 0; penable[k] = 0; pwrite[k] = 0; paddr[k] = '0; pwdata[k] = '0;
      end
      model_clear();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (pready[k] !== 0 || pslverr[k] !== 0 || prdata[k] !== 0 || err_count[k] !== 0) begin
            n_bad++;
            $display("FAIL reset[%0d] got rdy=%b err=%b rd=%h cnt=%0d want all 0", k, pready[k],
                     pslverr[k], prdata[k], err_count[k]);
         end
      end
   endtask

   task automatic test_basic();
      xfer(0, 1'b1, 8'h01, 32'h3, "basic_wr");
      bus_idle(0);
      xfer(0, 1'b0, 8'h01, 32'h0, "basic_rd");
      bus_idle(0);
   endtask

   task automatic test_wait_states();
      xfer(2, 1'b1, 8'h02, 32'hF, "ws3_wr");
      bus_idle(2);
      xfer(2, 1'b0, 8'h02, 32'h0, "ws3_rd");
      bus_idle(2);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3; k += 2) begin
         xfer(k, 1'b1, 8'h03, 32'h1F, "b2b_wr");
         xfer(k, 1'b0, 8'h03, 32'h0, "b2b_rd");
         bus_idle(k);
      end
   endtask

   task automatic test_error();
      xfer(0, 1'b0, 8'h80, 32'h0, "err_rd");
      bus_idle(0);
      xfer(0, 1'b1, 8'hFF, 32'hDEAD, "err_wr");
      bus_idle(0);
      check_errc(0, "err_count2");
      xfer(0, 1'b0, 8'h7F, 32'h0, "err_rd7f");
      bus_idle(0);
   endtask

   task automatic test_abort();
      @(posedge clk); #1;
      psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 8'h04; pwdata[1] = 32'h55;
      @(posedge clk); #1;
      penable[1] = 1;
      @(negedge clk);
      n_cmp++;
      if (pready[1] !== 1'b0) begin
         n_bad++; $display("FAIL abort_acc1 pready got %b want 0", pready[1]);
      end
      @(posedge clk); #1;
      psel[1] = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++;
         if (pready[1] !== 1'b0) begin
            n_bad++; $display("FAIL abort_after pready got %b want 0", pready[1]);
         end
         @(posedge clk); #1;
      end
      errc[1] = sat_inc(errc[1]);
      bus_idle(1);
      check_errc(1, "abort_count");
      xfer(1, 1'b0, 8'h04, 32'h0, "abort_rd");
      bus_idle(1);
   endtask

   task automatic test_idle_penable();
      @(posedge clk); #1;
      psel[1] = 1; penable[1] = 1; pwrite[1] = 1; paddr[1] = 8'h05; pwdata[1] = 32'hABCD;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_cmp++;
         if (pready[1] !== 1'b0) begin
            n_bad++; $display("FAIL idle_penable pready got %b want 0", pready[1]);
         end
      end
      bus_idle(1);
      xfer(1, 1'b0, 8'h05, 32'h0, "idle_pen_rd");
      bus_idle(1);
   endtask

   task automatic test_random(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         xfer(k, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 159)), $urandom, "rand");
         if ($urandom_range(0, 2) == 0) bus_idle(k);
      end
      bus_idle(k);
      check_errc(k, "rand_count");
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 260; i++) begin
         xfer(1, 1'b0, 8'($urandom_range(128, 255)), 32'h0, "sat_rd");
      end
      bus_idle(1);
      check_errc(1, "sat_count");
   endtask

   task automatic test_reset_mid();
      xfer(0, 1'b1, 8'h01, 32'h3, "rst_wr");
      bus_idle(0);
      xfer(0, 1'b0, 8'h01, 32'h0, "rst_rd_pre");
      #1 reset = 1'b1;
      #1;
      n_cmp++;
      if (pready[0] !== 0 || prdata[0] !== 0 || pslverr[0] !== 0 || err_count[0] !== 0) begin
         n_bad++;
         $display("FAIL reset_async got rdy=%b rd=%h err=%b cnt=%0d want all 0", pready[0],
                  prdata[0], pslverr[0], err_count[0]);
      end
      for (int k = 0; k < 3; k++) begin
         psel[k] = 0; penable[k] = 0;
      end
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      check_errc(1, "reset_count1");
      xfer(0, 1'b0, 8'h01, 32'h0, "rst_rd_post");
      bus_idle(0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wait_states();
      test_back_to_back();
      test_error();
      test_abort();
      test_idle_penable();
      for (int k = 0; k < 3; k++) test_random(k, 60);
      test_saturate();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
